// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response bus.
// The controller drives the request side; the memory answers with ack/rdata.
interface fetch_controller_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_controller.sv
// Front-end fetch controller: sequential PC, redirect flush, one out slot
// plus a single skid entry so back-to-back fetch survives a one-cycle stall.
module fetch_controller (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [31:0]               redirect_pc,
    fetch_controller_if.master        imem,
    output logic                      pc_load_n,
    output logic [31:0]               pc_next,
    output logic                      inst_valid,
    output logic [31:0]               inst,
    output logic [31:0]               inst_pc
);

    localparam logic [1:0] START = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        done;
    logic        consume;
    logic [31:0] addr_inc;

    assign done     = req_q & imem.imem_ack;
    assign consume  = out_valid_q & ~stall;
    assign addr_inc = addr_q + 32'd4;

    // Next-state: redirect wins, otherwise sequence fetches through the FSM.
    always_comb begin
        state_d      = state_q;
        next_addr_d  = next_addr_q;
        req_d        = req_q;
        addr_d       = addr_q;
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;
        pc_load_n    = 1'b1;
        pc_next      = next_addr_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (redirect_valid) begin
            next_addr_d  = redirect_pc;
            pc_load_n    = 1'b0;
            pc_next      = redirect_pc;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if (req_q && !imem.imem_ack) begin
                // Outstanding transfer must finish before a new request.
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = redirect_pc;
            end
        end else begin
            unique case (state_q)
                START: begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = next_addr_q;
                end
                FETCH: begin
                    if (done) begin
                        next_addr_d = addr_inc;
                        pc_load_n   = 1'b0;
                        pc_next     = addr_inc;
                        if (!out_valid_q || !stall) begin
                            out_valid_d = 1'b1;
                            out_inst_d  = imem.imem_rdata;
                            out_pc_d    = addr_q;
                            addr_d      = addr_inc;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_inst_d  = imem.imem_rdata;
                            skid_pc_d    = addr_q;
                            state_d      = HOLD;
                            req_d        = 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (consume) begin
                        out_valid_d  = 1'b1;
                        out_inst_d   = skid_inst_q;
                        out_pc_d     = skid_pc_q;
                        skid_valid_d = 1'b0;
                        state_d      = FETCH;
                        req_d        = 1'b1;
                        addr_d       = next_addr_q;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = next_addr_q;
                    end
                end
                default: begin
                    state_d = START;
                    req_d   = 1'b0;
                end
            endcase
        end

        if (reset) begin
            pc_load_n = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= START;
            next_addr_q  <= 32'd0;
            req_q        <= 1'b0;
            addr_q       <= 32'd0;
            out_valid_q  <= 1'b0;
            out_inst_q   <= 32'd0;
            out_pc_q     <= 32'd0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= 32'd0;
            skid_pc_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            next_addr_q  <= next_addr_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign inst_valid     = out_valid_q;
    assign inst           = out_inst_q;
    assign inst_pc        = out_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: per-cycle vector table for the bus/PC
// outputs plus a scoreboard for every instruction handed downstream.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        pc_load_n;
    logic [31:0] pc_next;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    fetch_controller_if bus ();

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus),
        .pc_load_n      (pc_load_n),
        .pc_next        (pc_next),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_rdata = mem_f(bus.imem_addr);

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic        push;
        logic        req;
        logic [31:0] addr;
        logic        ldn;
        logic [31:0] pcn;
        logic        iv;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic add(input logic rst, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic ack,
                       input logic push, input logic req,
                       input logic [31:0] addr, input logic ldn,
                       input logic [31:0] pcn, input logic iv);
        vec_t v;
        v.rst = rst; v.stall = st; v.redir = rv; v.rpc = rpc;
        v.ack = ack; v.push = push; v.req = req; v.addr = addr;
        v.ldn = ldn; v.pcn = pcn; v.iv = iv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    // Scoreboard: every consumed instruction must match the oldest expected.
    always @(negedge clk) begin
        if (reset === 1'b0 && inst_valid === 1'b1 && stall === 1'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: got pc %h inst %h, none expected",
                         inst_pc, inst);
            end else begin
                sb_t e;
                e = sb.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst) begin
                    n_err++;
                    $display("FAIL sb_inst: got pc %h inst %h want pc %h inst %h",
                             inst_pc, inst, e.pc, e.inst);
                end
            end
        end
    end

    initial begin
        int exp_a;
        // rst st rv rpc ack push | req addr ldn pcn iv
        add(0,0,0,0,1,0, 0,32'h0,1,32'h4-4,0);
        add(0,0,0,0,1,1, 1,32'h0,0,32'h4,0);
        add(0,0,0,0,1,1, 1,32'h4,0,32'h8,1);
        add(0,1,0,0,1,1, 1,32'h8,0,32'hC,1);
        add(0,1,0,0,0,0, 0,32'h8,1,32'hC,1);
        add(0,0,0,0,0,0, 0,32'h8,1,32'hC,1);
        add(0,0,0,0,0,0, 1,32'hC,1,32'hC,1);
        add(0,0,0,0,1,1, 1,32'hC,0,32'h10,0);
        add(0,0,1,32'h100,0,0, 1,32'h10,0,32'h100,1);
        add(0,0,0,0,0,0, 1,32'h10,1,32'h100,0);
        add(0,0,0,0,1,0, 1,32'h10,1,32'h100,0);
        add(0,0,1,32'h20,1,0, 1,32'h100,0,32'h20,0);
        add(0,0,1,32'h200,1,0, 1,32'h20,0,32'h200,0);
        add(0,0,0,0,1,1, 1,32'h200,0,32'h204,0);
        add(0,0,1,32'hFFFF_FFFC,1,0, 1,32'h204,0,32'hFFFF_FFFC,1);
        add(0,0,0,0,1,1, 1,32'hFFFF_FFFC,0,32'h0,0);
        add(0,0,0,0,0,0, 1,32'h0,1,32'h0,1);
        add(0,0,1,32'h1002,0,0, 1,32'h0,0,32'h1002,0);
        add(0,0,0,0,1,0, 1,32'h0,1,32'h1002,0);
        add(0,0,0,0,1,1, 1,32'h1002,0,32'h1006,0);
        add(0,0,0,0,0,0, 1,32'h1006,1,32'h1006,1);
        add(0,1,0,0,1,0, 1,32'h1006,0,32'h100A,0);
        add(0,1,0,0,1,0, 1,32'h100A,0,32'h100E,1);
        add(0,1,1,32'h300,0,0, 0,32'h100A,0,32'h300,1);
        add(0,0,0,0,0,0, 1,32'h300,1,32'h300,0);
        add(0,1,0,0,1,0, 1,32'h300,0,32'h304,0);
        add(0,1,0,0,1,0, 1,32'h304,0,32'h308,1);
        add(1,1,0,0,0,0, 0,32'h304,1,32'h308,1);
        add(0,0,0,0,1,0, 0,32'h0,1,32'h0,0);
        add(0,0,0,0,1,1, 1,32'h0,0,32'h4,0);
        add(0,0,0,0,0,0, 1,32'h4,1,32'h4,1);

        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        bus.imem_ack   = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            @(posedge clk);
            #1;
            reset          = v.rst;
            stall          = v.stall;
            redirect_valid = v.redir;
            redirect_pc    = v.rpc;
            bus.imem_ack   = v.ack;
            if (v.push) begin
                sb.push_back('{pc: v.addr, inst: mem_f(v.addr)});
            end
            @(negedge clk);
            chk("imem_req", i, {31'd0, bus.imem_req}, {31'd0, v.req});
            chk("imem_addr", i, bus.imem_addr, v.addr);
            chk("pc_load_n", i, {31'd0, pc_load_n}, {31'd0, v.ldn});
            chk("pc_next", i, pc_next, v.pcn);
            chk("inst_valid", i, {31'd0, inst_valid}, {31'd0, v.iv});
        end

        // Random ack, no stall: every completion must stream out in order.
        exp_a = 4;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            redirect_valid = 1'b0;
            stall          = 1'b0;
            bus.imem_ack   = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stream_req", c, {31'd0, bus.imem_req}, 32'd1);
            chk("stream_addr", c, bus.imem_addr, 32'(exp_a));
            if (bus.imem_ack) begin
                sb.push_back('{pc: 32'(exp_a), inst: mem_f(32'(exp_a))});
                exp_a += 4;
            end
        end
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("sb_left", 0, 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
